// File: rtl/alu_seq.sv
// alu_seq: registered ALU with an in/out valid handshake and an optional iterative MDU.
// Define ALU_MDU_EN to build the multiply/divide unit; without it every op[4]=1 code is illegal.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             negative_o,
  output logic             overflow_o,
  output logic             div_zero_o,
  output logic             illegal_o
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  logic             idle, accept, mdu_start, mdu_done;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;
  logic             mdu_zero, mdu_neg, mdu_ovf, mdu_dz;

  assign in_ready_o = idle && rst_ni;
  assign accept     = in_valid_i && in_ready_o;

  // ---------------------------------------------------------------------------
  // Base operations
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w, sub_w, sll_w, srl_w, sra_w;
  logic [WIDTH-1:0] base_r;
  logic             base_c, base_v;

  assign shamt = a_i[SHW-1:0];
  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};
  // One extra bit catches the last bit shifted out; it stays 0 for a zero shift.
  assign sll_w = {1'b0, b_i} << shamt;
  assign srl_w = {b_i, 1'b0} >> shamt;
  assign sra_w = $signed({b_i, 1'b0}) >>> shamt;

  always_comb begin
    base_r = '0;
    base_c = 1'b0;
    base_v = 1'b0;
    case (op_i[3:0])
      4'b0000: begin
        base_r = add_w[MSB:0];
        base_c = add_w[WIDTH];
      end
      4'b0010: begin
        base_r = add_w[MSB:0];
        base_c = add_w[WIDTH];
        base_v = (a_i[MSB] == b_i[MSB]) && (add_w[MSB] != a_i[MSB]);
      end
      4'b0001: begin
        base_r = sub_w[MSB:0];
        base_c = sub_w[WIDTH];
      end
      4'b0011: begin
        base_r = sub_w[MSB:0];
        base_c = sub_w[WIDTH];
        base_v = (a_i[MSB] != b_i[MSB]) && (sub_w[MSB] != a_i[MSB]);
      end
      4'b0100: base_r = a_i & b_i;
      4'b0101: base_r = a_i | b_i;
      4'b0110: base_r = a_i ^ b_i;
      4'b0111: base_r = ~(a_i | b_i);
      4'b1000, 4'b1001: base_r = {b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b1010: base_r = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
      4'b1011: base_r = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      4'b1100: begin
        base_r = sra_w[WIDTH:1];
        base_c = sra_w[0];
      end
      4'b1101: begin
        base_r = srl_w[WIDTH:1];
        base_c = srl_w[0];
      end
      default: begin
        base_r = sll_w[MSB:0];
        base_c = sll_w[WIDTH];
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide unit
  // ---------------------------------------------------------------------------
`ifdef ALU_MDU_EN
  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic               is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d, ovf_q, ovf_d;
  logic               a_neg, b_neg, div_ge;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_sh, div_sub;
  logic [2*WIDTH-1:0] prod;

  assign idle      = (state_q == StIdle);
  assign mdu_start = accept && op_i[4] && (op_i[3:2] == 2'b00);
  assign mdu_done  = (state_q == StFix);

  assign a_neg = op_i[0] && a_i[MSB];
  assign b_neg = op_i[0] && b_i[MSB];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  // acc_lo holds the multiplier (mul) or dividend/quotient (div); acc_hi the partial result.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh  = {acc_hi_q, acc_lo_q[MSB]};
  assign div_sub = div_sh - {1'b0, opb_q};
  assign div_ge  = (div_sh >= {1'b0, opb_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (mdu_start) begin
          state_d  = StRun;
          cnt_d    = SHW'(WIDTH - 1);
          acc_hi_d = '0;
          acc_lo_d = a_abs;
          opb_d    = b_abs;
          is_div_d = op_i[1];
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dz_d     = op_i[1] && (b_i == '0);
          ovf_d    = (op_i[1:0] == 2'b11) && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_i);
        end
      end
      StRun: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_sub[MSB:0] : div_sh[MSB:0];
          acc_lo_d = {acc_lo_q[MSB-1:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[MSB:1]};
        end
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) state_d = StFix;
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sign correction applied while in FIX; a zero divisor leaves |a| in acc_hi.
  always_comb begin
    prod     = neg_lo_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    mdu_hi   = prod[2*WIDTH-1:WIDTH];
    mdu_lo   = prod[MSB:0];
    mdu_zero = (prod == '0);
    mdu_neg  = prod[2*WIDTH-1];
    if (is_div_q) begin
      mdu_lo   = dz_q ? '1 : (neg_lo_q ? -acc_lo_q : acc_lo_q);
      mdu_hi   = neg_hi_q ? -acc_hi_q : acc_hi_q;
      mdu_zero = (mdu_lo == '0);
      mdu_neg  = mdu_lo[MSB];
    end
  end

  assign mdu_ovf = ovf_q;
  assign mdu_dz  = dz_q;
`else
  assign idle      = 1'b1;
  assign mdu_start = 1'b0;
  assign mdu_done  = 1'b0;
  assign mdu_hi    = '0;
  assign mdu_lo    = '0;
  assign mdu_zero  = 1'b0;
  assign mdu_neg   = 1'b0;
  assign mdu_ovf   = 1'b0;
  assign mdu_dz    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Result registers; flags_q = {zero, carry, negative, overflow, div_zero, illegal}
  // ---------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] r_q, r_d, hi_q, hi_d, lo_q, lo_d;
  logic [5:0]       flags_q, flags_d;

  always_comb begin
    out_valid_d = 1'b0;
    r_d         = r_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    flags_d     = flags_q;
    if (mdu_done) begin
      out_valid_d = 1'b1;
      r_d         = mdu_lo;
      hi_d        = mdu_hi;
      lo_d        = mdu_lo;
      flags_d     = {mdu_zero, 1'b0, mdu_neg, mdu_ovf, mdu_dz, 1'b0};
    end else if (accept && !op_i[4]) begin
      out_valid_d = 1'b1;
      r_d         = base_r;
      flags_d     = {(base_r == '0), base_c, base_r[MSB], base_v, 2'b00};
    end else if (accept && !mdu_start) begin
      out_valid_d = 1'b1;
      r_d         = '0;
      hi_d        = '0;
      lo_d        = '0;
      flags_d     = 6'b000001;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign r_o         = r_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign zero_o      = flags_q[5];
  assign carry_o     = flags_q[4];
  assign negative_o  = flags_q[3];
  assign overflow_o  = flags_q[2];
  assign div_zero_o  = flags_q[1];
  assign illegal_o   = flags_q[0];

endmodule
